nco_config_controller: RTL

//  User-facing configuration sequencer for the NCO core. Walks the operator through

---
 rtl/nco_pkg.sv | 35 +++
 rtl/btn_edge_detect.sv | 26 ++
 rtl/nco_config_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO configuration controller.
//   cfg_state_t : controller FSM states; encodings are visible on state_out
//   wave_t      : waveform codes driven on cfg_wave
//   wave_step() : modulo-4 step of the waveform selection
package nco_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL_WAVE = 3'd1,
    SEL_FREQ = 3'd2,
    COMMIT   = 3'd3,
    HOLD     = 3'd4
  } cfg_state_t;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAW      = 2'd3
  } wave_t;

  // Roughly 1 kHz per frequency index at 1 MHz with a 32-bit accumulator.
  localparam int unsigned FTW_STEP_DEFAULT = 4295;

  // Width of the frequency index; disp_value packs it as {4'b0, freq_idx}.
  localparam int unsigned FREQ_W = 4;

  // Waveform selection steps wrap in both directions (SAW+1 -> SINE, SINE-1 -> SAW).
  function automatic wave_t wave_step(input wave_t w, input logic up);
    logic [1:0] v;
    v = up ? (w + 2'd1) : (w - 2'd1);
    return wave_t'(v);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one already-synchronised button level.
//   clk_1MHz : system clock
//   rst      : synchronous active-high reset, clears the history register
//   i_level  : button level
//   o_pulse  : high for the single cycle where the level is high and was low last cycle
module btn_edge_detect (
  input  logic clk_1MHz,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  // Combinational so the FSM can act on the same clock edge that first samples the level.
  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/nco_config_controller.sv
// Button-driven configuration sequencer for the NCO core. After a startup delay the operator
// picks a waveform, then a frequency index; the choice is offered to the NCO datapath over a
// valid/ready handshake and a display hold period follows.
// Ports:
//   clk_1MHz, rst                : clock, synchronous active-high reset
//   btn_next, btn_up, btn_down   : synchronised button levels (rising edges are the events)
//   cfg_ready / cfg_valid        : handshake with the NCO core
//   cfg_wave, cfg_ftw            : committed waveform code and frequency tuning word
//   state_out                    : FSM state encoding for the display driver
//   disp_value                   : value under edit ({4'b0,freq_idx} in SEL_FREQ, else wave_sel)
//   phase_clr                    : only with NCO_PHASE_SYNC_EN defined; high during the
//                                  handshake cycle so the accumulator restarts at phase 0
module nco_config_controller
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned FTW_STEP    = FTW_STEP_DEFAULT,
  parameter int unsigned FREQ_MAX    = 15,
  parameter int unsigned HOLD_CYCLES = 3000000
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             cfg_ready,
  output logic             cfg_valid,
  output logic [1:0]       cfg_wave,
  output logic [ACC_W-1:0] cfg_ftw,
  output logic [2:0]       state_out,
  output logic [7:0]       disp_value
`ifdef NCO_PHASE_SYNC_EN
  ,
  output logic             phase_clr
`endif
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FREQ_W-1:0] FreqMax = FREQ_W'(FREQ_MAX);

  logic w_next, w_up, w_down;
  logic w_up_only, w_down_only;

  btn_edge_detect u_edge_next (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .i_level  (btn_next),
    .o_pulse  (w_next)
  );

  btn_edge_detect u_edge_up (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .i_level  (btn_up),
    .o_pulse  (w_up)
  );

  btn_edge_detect u_edge_down (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .i_level  (btn_down),
    .o_pulse  (w_down)
  );

  // Simultaneous up and down edges cancel.
  assign w_up_only   = w_up & ~w_down;
  assign w_down_only = w_down & ~w_up;

  cfg_state_t        r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  wave_t             r_wave_sel, w_wave_sel_d;
  logic [FREQ_W-1:0] r_freq_idx, w_freq_idx_d;
  logic              r_cfg_valid, w_cfg_valid_d;
  wave_t             r_cfg_wave, w_cfg_wave_d;
  logic [ACC_W-1:0]  r_cfg_ftw, w_cfg_ftw_d;
  logic [ACC_W-1:0]  w_ftw;
  logic              w_xfer;

  assign w_ftw  = ACC_W'((ACC_W'(r_freq_idx) + ACC_W'(1)) * ACC_W'(FTW_STEP));
  assign w_xfer = r_cfg_valid & cfg_ready;

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wave_sel  <= SINE;
      r_freq_idx  <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_wave  <= SINE;
      r_cfg_ftw   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_wave_sel  <= w_wave_sel_d;
      r_freq_idx  <= w_freq_idx_d;
      r_cfg_valid <= w_cfg_valid_d;
      r_cfg_wave  <= w_cfg_wave_d;
      r_cfg_ftw   <= w_cfg_ftw_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_wave_sel_d  = r_wave_sel;
    w_freq_idx_d  = r_freq_idx;
    w_cfg_valid_d = r_cfg_valid;
    w_cfg_wave_d  = r_cfg_wave;
    w_cfg_ftw_d   = r_cfg_ftw;

    case (r_state)
      IDLE: begin
        if (r_cnt == CntLast) begin
          w_state_d = SEL_WAVE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end

      // A next edge wins over a coincident up/down edge.
      SEL_WAVE: begin
        if (w_next) begin
          w_state_d = SEL_FREQ;
        end else if (w_up_only) begin
          w_wave_sel_d = wave_step(r_wave_sel, 1'b1);
        end else if (w_down_only) begin
          w_wave_sel_d = wave_step(r_wave_sel, 1'b0);
        end
      end

      SEL_FREQ: begin
        if (w_next) begin
          w_state_d     = COMMIT;
          w_cfg_valid_d = 1'b1;
          w_cfg_wave_d  = r_wave_sel;
          w_cfg_ftw_d   = w_ftw;
        end else if (w_up_only && (r_freq_idx != FreqMax)) begin
          w_freq_idx_d = r_freq_idx + FREQ_W'(1);
        end else if (w_down_only && (r_freq_idx != '0)) begin
          w_freq_idx_d = r_freq_idx - FREQ_W'(1);
        end
      end

      // Buttons are ignored while the offer is outstanding.
      COMMIT: begin
        if (w_xfer) begin
          w_state_d     = HOLD;
          w_cfg_valid_d = 1'b0;
          w_cnt_d       = '0;
        end
      end

      HOLD: begin
        if (w_next || (r_cnt == CntLast)) begin
          w_state_d = SEL_WAVE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end

      // Encodings 5-7 recover to IDLE.
      default: begin
        w_state_d     = IDLE;
        w_cnt_d       = '0;
        w_cfg_valid_d = 1'b0;
      end
    endcase
  end

  assign cfg_valid  = r_cfg_valid;
  assign cfg_wave   = r_cfg_wave;
  assign cfg_ftw    = r_cfg_ftw;
  assign state_out  = r_state;
  assign disp_value = (r_state == SEL_FREQ) ? {4'b0, r_freq_idx} : {6'b0, r_wave_sel};

`ifdef NCO_PHASE_SYNC_EN
  assign phase_clr = w_xfer;
`endif

endmodule
